// File: rtl/sorted_ram_loader.sv
// sorted_ram_loader
// Keeps up to 32 unsigned 8-bit values in non-decreasing order. It inserts each new value
// by moving a hole downwards one slot per cycle. A registered read port exposes the array
// as the lookup memory for the binary-search engine.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset (clears array, count, state)
//   clear_i     synchronous empty request; drops any pending insertion, array untouched
//   in_valid_i  in_data_i holds a value to insert
//   in_data_i   8-bit unsigned value
//   in_ready_o  a value can be accepted this cycle
//   rd_addr_i   5-bit read location
//   rd_data_o   registered mem[rd_addr_i]
//   count_o     number of valid entries (0..32)
//   full_o      count_o == 32
//   busy_o      insertion in progress, array contents not stable
module sorted_ram_loader (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic [5:0] count_o,
    output logic       full_o,
    output logic       busy_o
);

    typedef enum logic [0:0] {StIdle, StInsert} state_e;

    state_e      state_q, state_d;
    logic [7:0]  mem_q [32];
    logic [7:0]  v_q, v_d;
    logic [4:0]  p_q, p_d;
    logic [5:0]  count_q, count_d;
    logic [7:0]  rd_data_q;

    logic        wr_en;
    logic [7:0]  wr_val;
    logic [7:0]  prev_val;

    // Entry just below the hole; only meaningful when p_q != 0.
    assign prev_val = mem_q[p_q - 5'd1];

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            v_q       <= '0;
            p_q       <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            p_q       <= p_d;
            count_q   <= count_d;
            rd_data_q <= mem_q[rd_addr_i];
            if (wr_en) begin
                mem_q[p_q] <= wr_val;
            end
        end
    end

    // Next-state and insertion step.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        p_d     = p_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_val  = v_q;
        if (clear_i) begin
            count_d = '0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_o) begin
                        v_d     = in_data_i;
                        p_d     = count_q[4:0];
                        state_d = StInsert;
                    end
                end
                StInsert: begin
                    // <= keeps equal values in arrival order.
                    if (p_q == 5'd0 || prev_val <= v_q) begin
                        wr_en   = 1'b1;
                        wr_val  = v_q;
                        count_d = count_q + 6'd1;
                        state_d = StIdle;
                    end else begin
                        wr_en   = 1'b1;
                        wr_val  = prev_val;
                        p_d     = p_q - 5'd1;
                    end
                end
            endcase
        end
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        full_o     = (count_q == 6'd32);
        busy_o     = (state_q == StInsert);
        in_ready_o = (state_q == StIdle) && !full_o;
        count_o    = count_q;
        rd_data_o  = rd_data_q;
    end

endmodule

// File: tb/tb_sorted_ram_loader.sv
module tb_sorted_ram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [5:0] count;
    logic       full;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    // Reference: the sorted contents as a queue.
    logic [7:0] model[$];

    always #5 clk = ~clk;

    sorted_ram_loader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .count_o    (count),
        .full_o     (full),
        .busy_o     (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(in_ready), 1);
        chk({tag, "_rd"}, int'(rd_data), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Reset asserted mid-cycle; outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
    endtask

    task automatic model_insert(input logic [7:0] val);
        int pos;
        pos = model.size();
        for (int i = 0; i < model.size(); i++) begin
            if (model[i] > val) begin
                pos = i;
                break;
            end
        end
        model.insert(pos, val);
    endtask

    // Accepts val, measures INSERT length and compares with 1 + (#entries > val).
    task automatic do_insert(input logic [7:0] val);
        int g;
        int w;
        int cyc;
        g = 0;
        foreach (model[i]) if (model[i] > val) g++;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_accept", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = val;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("insert_len", cyc, g + 1);
        model_insert(val);
        chk("count_after_insert", int'(count), model.size());
    endtask

    task automatic sweep_model(input string tag);
        for (int i = 0; i < model.size(); i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk(tag, int'(rd_data), int'(model[i]));
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk(tag, int'(rd_data), 0);
        end
    endtask

    initial begin
        // Reset / idle.
        #3 chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        do_reset("reset_idle");
        sweep_zero("reset_mem");

        // Ordered insertion.
        do_insert(8'd50);
        do_insert(8'd10);
        do_insert(8'd30);
        chk("ordered_busy", int'(busy), 0);
        sweep_model("ordered_rd");

        // Duplicates and extremes.
        do_reset("reset_dup");
        do_insert(8'h80);
        do_insert(8'h00);
        do_insert(8'hFF);
        do_insert(8'h80);
        sweep_model("dup_rd");

        // Full: descending worst case, then hold 99.
        do_reset("reset_full");
        for (int k = 31; k >= 0; k--) do_insert(8'(k));
        chk("full_count", int'(count), 32);
        chk("full_flag", int'(full), 1);
        chk("full_ready", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("full_hold_busy", int'(busy), 0);
            chk("full_hold_count", int'(count), 32);
        end
        in_valid = 1'b0;
        sweep_model("full_rd");

        // Reset mid-insert.
        do_reset("reset_pre_mid");
        do_insert(8'd10);
        do_insert(8'd20);
        do_insert(8'd30);
        in_valid = 1'b1;
        in_data  = 8'd5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy1", int'(busy), 1);
        @(negedge clk);
        chk("mid_busy2", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_count", int'(count), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        sweep_zero("mid_mem");
        do_insert(8'd7);
        sweep_model("mid_rd");

        // Clear with coincident in_valid.
        do_reset("reset_clear");
        do_insert(8'd3);
        do_insert(8'd1);
        do_insert(8'd2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_busy", int'(busy), 0);
        model.delete();
        do_insert(8'd42);
        sweep_model("clear_rd");

        // Randomized fill with duplicates likely from a narrow range.
        do_reset("reset_rand");
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) do_insert(8'($urandom_range(0, 7)));
            else do_insert(8'($urandom_range(0, 255)));
        end
        sweep_model("rand_rd");
        while (model.size() < 32) do_insert(8'($urandom_range(0, 255)));
        chk("rand_full", int'(full), 1);
        sweep_model("rand_full_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
